// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared state encoding and width helper for the serial multiplier
//
// Purpose: FSM state type for mul_ser_gen and a constant-foldable clog2
//          used to size the iteration counter.
// Ports:   none (package).

package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_ser_addsub.sv
// rtl/mul_ser_addsub.sv - registered accumulator stage: p <= 0, p + t, p - t or hold
//
// Purpose: partial-product accumulator of the serial multiplier. Pure datapath;
//          the caller decides when to clear, add or subtract.
// Ports:
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset, clears p
//   clr      in  p <= 0 (takes priority over en)
//   en       in  accumulate this cycle
//   sub      in  when en: 1 = subtract t, 0 = add t
//   t        in  W-bit shifted multiplicand
//   p        out W-bit accumulator, arithmetic modulo 2^W

module mul_ser_addsub #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic         sub,
  input  logic [W-1:0] t,
  output logic [W-1:0] p
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p <= '0;
    end else if (clr) begin
      p <= '0;
    end else if (en) begin
      p <= sub ? (p - t) : (p + t);
    end
  end

endmodule

// File: rtl/mul_ser_gen.sv
// rtl/mul_ser_gen.sv - parametrised serial shift-add multiplier, signed or unsigned per op
//
// Purpose: one partial product per clock, scanning a LSB-first. Result after
//          WA+1 edges from the start-sampling edge; one result per WA+2 cycles.
// Ports:
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset
//   start    in  request, sampled only while ready=1
//   tc       in  1 = operands two's complement, 0 = unsigned (captured with start)
//   x        in  WX-bit multiplicand (captured with start)
//   a        in  WA-bit multiplier (captured with start)
//   ready    out high in IDLE only
//   done     out one-cycle pulse when y carries a new product
//   y        out WY-bit product, held until the next done

module mul_ser_gen
  import arith_pkg::*;
#(
  parameter int WX = 8,
  parameter int WA = 8,
  parameter int WY = WX + WA
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          tc,
  input  logic [WX-1:0] x,
  input  logic [WA-1:0] a,
  output logic          ready,
  output logic          done,
  output logic [WY-1:0] y
);

  localparam int CW = clog2(WA) + 1;

  state_t        state, state_nxt;
  logic [WA-1:0] a_reg;
  logic          tc_reg;
  logic [WY-1:0] t;
  logic [WY-1:0] p;
  logic [CW-1:0] count;
  logic          last_iter;
  logic          acc_clr;
  logic          acc_en;
  logic          acc_sub;

  assign last_iter = (count == CW'(WA - 1));
  assign ready     = (state == IDLE);

  // Next state and accumulator control. In two's complement the MSB of a
  // carries weight -2^(WA-1), so its partial product is subtracted.
  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    acc_sub   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          acc_clr   = 1'b1;
        end
      end
      RUN: begin
        acc_en  = a_reg[0];
        acc_sub = tc_reg & last_iter;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      tc_reg <= 1'b0;
      t      <= '0;
      count  <= '0;
      y      <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == DONE);
      if (state == DONE) y <= p;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= a;
            tc_reg <= tc;
            // Sign-extend x in signed mode so shifted copies keep their sign.
            t      <= tc ? {{WA{x[WX-1]}}, x} : {{WA{1'b0}}, x};
            count  <= '0;
          end
        end
        RUN: begin
          a_reg <= a_reg >> 1;
          t     <= t << 1;
          count <= count + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  mul_ser_addsub #(
    .W (WY)
  ) u_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (acc_clr),
    .en      (acc_en),
    .sub     (acc_sub),
    .t       (t),
    .p       (p)
  );

endmodule

// File: tb/tb_mul_ser_gen.sv
// tb/tb_mul_ser_gen.sv - scoreboard bench for mul_ser_gen (8x8 and 12x4 builds)

module tb_mul_ser_gen;

  localparam int WX  = 8;
  localparam int WA  = 8;
  localparam int WX2 = 12;
  localparam int WA2 = 4;

  typedef struct {
    logic [15:0] y;
    int          edge_n;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, tc;
  logic [7:0]  x, a;
  logic        ready, done;
  logic [15:0] y;
  logic        start2, tc2;
  logic [11:0] x2;
  logic [3:0]  a2;
  logic        ready2, done2;
  logic [15:0] y2;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic [15:0] last_y  = '0;
  logic [15:0] last_y2 = '0;
  int   last_issue;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_ser_gen #(.WX(WX), .WA(WA)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .tc(tc), .x(x), .a(a),
    .ready(ready), .done(done), .y(y)
  );

  mul_ser_gen #(.WX(WX2), .WA(WA2)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start2), .tc(tc2), .x(x2), .a(a2),
    .ready(ready2), .done(done2), .y(y2)
  );

  // Reference: interpret operands as integers per mode, multiply, keep WX+WA bits.
  function automatic logic [15:0] ref_mul(input logic [63:0] xv, input logic [63:0] av,
                                          input int wx, input int wa, input bit s);
    longint xs, as_, pr;
    xs  = longint'(xv & ((64'd1 << wx) - 1));
    as_ = longint'(av & ((64'd1 << wa) - 1));
    if (s && xv[wx-1]) xs  = xs  - (longint'(1) << wx);
    if (s && av[wa-1]) as_ = as_ - (longint'(1) << wa);
    pr = xs * as_;
    return 16'(pr);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 8x8 build.
  always @(negedge clk) begin
    if (!reset_n) begin
      check("a_reset_y", y, 0);
      check("a_reset_done", done, 0);
      check("a_reset_ready", ready, 1);
    end else begin
      if (done) begin
        if (qa.size() == 0) begin
          check("a_done_unexpected", done, 0);
        end else begin
          ea = qa.pop_front();
          check("a_y", y, ea.y);
          check("a_latency", cyc, ea.edge_n + WA + 1);
        end
        last_y = y;
      end else begin
        check("a_y_hold", y, last_y);
      end
      if (qa.size() > 0 && cyc >= qa[0].edge_n && cyc <= qa[0].edge_n + WA)
        check("a_ready_busy", ready, 0);
    end
  end

  // Monitor for the 12x4 build.
  always @(negedge clk) begin
    if (reset_n) begin
      if (done2) begin
        if (qb.size() == 0) begin
          check("b_done_unexpected", done2, 0);
        end else begin
          eb = qb.pop_front();
          check("b_y", y2, eb.y);
          check("b_latency", cyc, eb.edge_n + WA2 + 1);
        end
        last_y2 = y2;
      end else begin
        check("b_y_hold", y2, last_y2);
      end
    end
  end

  // Called at a negedge. Waits for ready, presents the op, returns one negedge later.
  task automatic issue_a(input logic [7:0] xv, input logic [7:0] av, input bit tv,
                         input bit held, input bit chk_period);
    int guard = 0;
    while (ready !== 1'b1) begin
      @(negedge clk);
      guard++;
      start = held ? 1'b1 : 1'($urandom);
      x = 8'($urandom); a = 8'($urandom); tc = 1'($urandom);
      if (guard > 200) begin
        check("a_ready_timeout", ready, 1);
        return;
      end
    end
    start = 1'b1; x = xv; a = av; tc = tv;
    if (chk_period) check("a_b2b_period", cyc + 1 - last_issue, WA + 2);
    last_issue = cyc + 1;
    qa.push_back('{y: ref_mul(64'(xv), 64'(av), WX, WA, tv), edge_n: cyc + 1});
    @(negedge clk);
    start = held ? 1'b1 : 1'($urandom);
    x = 8'($urandom); a = 8'($urandom); tc = 1'($urandom);
  endtask

  task automatic issue_b(input logic [11:0] xv, input logic [3:0] av, input bit tv);
    int guard = 0;
    while (ready2 !== 1'b1) begin
      @(negedge clk);
      guard++;
      start2 = 1'($urandom);
      x2 = 12'($urandom); a2 = 4'($urandom); tc2 = 1'($urandom);
      if (guard > 200) begin
        check("b_ready_timeout", ready2, 1);
        return;
      end
    end
    start2 = 1'b1; x2 = xv; a2 = av; tc2 = tv;
    qb.push_back('{y: ref_mul(64'(xv), 64'(av), WX2, WA2, tv), edge_n: cyc + 1});
    @(negedge clk);
    start2 = 1'($urandom);
    x2 = 12'($urandom); a2 = 4'($urandom); tc2 = 1'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    start = 1'b0; start2 = 1'b0;
    while ((qa.size() != 0 || qb.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    start = 1'b0; tc = 1'b0; x = '0; a = '0;
    start2 = 1'b0; tc2 = 1'b0; x2 = '0; a2 = '0;
    last_issue = 0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Directed operands, including same bits in both modes and zero operands.
    issue_a(8'd200, 8'd255, 1'b0, 1'b0, 1'b0);
    issue_a(8'h80,  8'h80,  1'b1, 1'b0, 1'b0);
    issue_a(8'h7F,  8'h80,  1'b1, 1'b0, 1'b0);
    issue_a(8'hFF,  8'hFF,  1'b0, 1'b0, 1'b0);
    issue_a(8'hFF,  8'hFF,  1'b1, 1'b0, 1'b0);
    issue_a(8'h00,  8'hA5,  1'b0, 1'b0, 1'b0);
    issue_a(8'h5A,  8'h00,  1'b1, 1'b0, 1'b0);
    issue_a(8'h7F,  8'h7F,  1'b1, 1'b0, 1'b0);
    drain();

    // start held high: one op every WA+2 cycles, operands only sampled in IDLE.
    for (int i = 0; i < 12; i++)
      issue_a(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, i != 0);
    drain();

    for (int i = 0; i < 40; i++)
      issue_a(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    drain();

    // Abort at count=4: no done for that op, y back to 0, then a clean op.
    issue_a(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    qa.delete();
    last_y = '0; last_y2 = '0;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (12) @(negedge clk);
    issue_a(8'd3, 8'd5, 1'b0, 1'b0, 1'b0);
    drain();

    // 12x4 build.
    issue_b(12'h800, 4'h7, 1'b1);
    issue_b(12'h800, 4'h8, 1'b1);
    issue_b(12'hFFF, 4'hF, 1'b0);
    for (int i = 0; i < 15; i++)
      issue_b(12'($urandom), 4'($urandom), 1'($urandom));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_ser_gen.md
Name: mul_ser_gen

Overview:
Parametrised serial shift-add multiplier. Computes one partial product per clock, scanning multiplier operand a LSB-first. Supports signed (two's complement) and unsigned operands, selected per operation. A start/ready/done handshake lets a controller or datapath sequencer issue back-to-back multiplies. Sits in the arithmetic library beside the fixed 8x8 serial multiplier for area-critical MAC and filter paths.

Parameters:
WX, 8, width of multiplicand x (>=2)
WA, 8, width of multiplier a (>=2); also the number of iteration cycles
WY, WX+WA, product width (derived, not to be overridden)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when ready=1
tc  in  1  1 = both operands signed two's complement, 0 = both unsigned; captured with start
x  in  WX  multiplicand; captured with start
a  in  WA  multiplier; captured with start
ready  out  1  high in IDLE only
done  out  1  one-cycle pulse: y holds a new result
y  out  WY  product; held until the next done

Behaviour:
- Reset (async assert, sync release): state=IDLE, ready=1, done=0, y=0, internal p/t/a_reg/count=0.
- States: IDLE, RUN, DONE.
- IDLE: on start=1, capture a_reg<=a and tc_reg<=tc. t<=x extended to WY bits (sign-extended if tc=1, zero-extended if tc=0). p<=0, count<=0, go to RUN. On start=0, stay in IDLE.
- RUN, one iteration per cycle, count 0..WA-1:
  - a_reg[0]=1 and not (tc_reg=1 and count=WA-1): p<=p+t.
  - a_reg[0]=1 and tc_reg=1 and count=WA-1: p<=p-t (negative MSB weight).
  - Always: a_reg<=a_reg>>1, t<=t<<1, count<=count+1.
  - When count=WA-1, go to DONE after this iteration.
- DONE: y<=p, done<=1 for exactly this cycle, then go to IDLE.
- Arithmetic is modulo 2^WY. The result is exact for all operand values in both modes, so no overflow can occur.
- Latency: start sampled at edge E0; y/done update at edge E0+WA+1. Throughput is one result per WA+2 cycles; start held high re-issues immediately once back in IDLE.
- start while RUN/DONE is ignored; inputs x/a/tc are don't-care outside the IDLE sampling cycle.
- Operand change during RUN has no effect on the operation in progress.
- count width = clog2(WA)+1; no wrap is possible before the exit condition.
- reset_n low mid-operation aborts immediately. y returns to 0, no done pulse is emitted, and the block is ready=1 after release.
- x=0 or a=0 gives y=0 after full latency; there is no early termination.

Decomposition:
- Shared package/include (arith_pkg): state encoding constants IDLE/RUN/DONE, and a clog2 function for count width.
- One natural sub-module, mul_ser_addsub: WY-bit registered accumulator stage performing p±t or hold, controlled by en/sub. All control stays in mul_ser_gen.

Test Plan:
- WX=WA=8, tc=0, x=200, a=255 -> y=51000 (0xC738), done pulses 9 edges after start edge; ready low during those cycles.
- tc=1, x=0x80 (-128), a=0x80 (-128) -> y=0x4000. tc=1, x=0x7F, a=0x80 -> y=0xC080 (-16256).
- Same bits, mode matters: x=a=0xFF, tc=0 -> y=0xFE01; tc=1 -> y=0x0001.
- start held high continuously with changing operands -> one result every 10 cycles. Operands sampled only in IDLE; y stable between done pulses.
- Pulse reset_n low at RUN count=4 -> y=0, done never pulses for that op. Next start with x=3, a=5, tc=0 -> y=15.
- Build with WX=12, WA=4: tc=1, x=0x800 (-2048), a=0x7 (7) -> y=0xC800 (-14336), latency 5 cycles.
